ntt_layer_ctrl: RTL and testbench

- Initiator side of the butterfly-unit interface. Schedules a full in-place 256-point forward NTT or inverse NTT, for Kyber or Dilithium.
- Per cycle it issues reads of coefficient pairs and twiddle addresses to synchronous RAM/ROM. The read data feeds the BFU.
- It writes the BFU results back in place at the same addresses, delayed by the pipeline latency.
- It enforces the layer-to-layer memory dependency by draining the pipeline between layers.

---
 rtl/ntt_pkg.sv | 38 +++
 rtl/ntt_addr_gen.sv | 37 +++
 rtl/ntt_layer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ntt_layer_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM state type and write-back delay-line entry for the
// 256-point NTT layer controller.
package ntt_pkg;

  localparam int N          = 256;
  localparam int HALF_N     = N / 2;
  localparam int ADDR_W     = 8;

  localparam int MEM_RD_LAT = 1;
  localparam int BFU_LAT    = 4;
  localparam int PIPE_LAT   = MEM_RD_LAT + BFU_LAT;
  localparam int DRAIN_CNT_W = $clog2(PIPE_LAT);

  localparam int NL_KYBER     = 7;
  localparam int NL_DILITHIUM = 8;

  // Modulus and Montgomery inverse (q^-1 mod 2^16 / 2^32), index 0 = Kyber, 1 = Dilithium.
  localparam logic [31:0] Q_TBL    [2] = '{32'd3329,  32'd8380417};
  localparam logic [31:0] QINV_TBL [2] = '{32'd62209, 32'd58728449};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
  } wb_entry_t;

  function automatic logic [2:0] last_layer(input logic algo);
    return algo ? 3'(NL_DILITHIUM - 1) : 3'(NL_KYBER - 1);
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: maps (layer, butterfly index,
// direction) to the coefficient pair and twiddle ROM address.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [2:0]        i_layer,
  input  logic [6:0]        i_j,
  input  logic              i_intt,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [ADDR_W-1:0] o_tw_addr
);

  logic [2:0]        w_shift;
  logic [ADDR_W-1:0] w_j;
  logic [ADDR_W-1:0] w_len;
  logic [ADDR_W-1:0] w_grp;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_tw_fwd;
  logic [ADDR_W-1:0] w_tw_inv;

  // len = 128 >> L is a power of two, so divide/modulo reduce to shift/mask.
  assign w_shift = 3'd7 - i_layer;
  assign w_j     = {1'b0, i_j};
  assign w_len   = 8'd1 << w_shift;
  assign w_grp   = w_j >> w_shift;
  assign w_off   = w_j & (w_len - 8'd1);

  assign o_addr_a = ((w_grp << 1) << w_shift) + w_off;
  assign o_addr_b = o_addr_a + w_len;

  // At L=7 the 8-bit (2<<L) wraps to 0, giving 255-g as intended.
  assign w_tw_fwd  = (8'd1 << i_layer) + w_grp;
  assign w_tw_inv  = (8'd2 << i_layer) - 8'd1 - w_grp;
  assign o_tw_addr = i_intt ? w_tw_inv : w_tw_fwd;

endmodule

// File: rtl/ntt_layer_ctrl.sv
// In-place forward/inverse NTT scheduler: issues one butterfly per cycle,
// drains the BFU pipeline between layers and writes results back in place.
module ntt_layer_ctrl
  import ntt_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_intt,
  input  logic              i_algo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr_a,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic [ADDR_W-1:0] o_tw_addr,
  output logic              o_bfu_intt,
  output logic              o_bfu_algo,
  output logic              o_bfu_skip,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr_a,
  output logic [ADDR_W-1:0] o_wr_addr_b
);

  state_e                 r_state;
  logic                   r_intt;
  logic                   r_algo;
  logic [2:0]             r_layer;
  logic [6:0]             r_j;
  logic [DRAIN_CNT_W-1:0] r_drain_cnt;
  wb_entry_t              r_dly [PIPE_LAT];

  logic [2:0]        w_gen_layer;
  logic [6:0]        w_gen_j;
  logic              w_gen_intt;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_tw;
  logic              w_last_layer;
  wb_entry_t         w_issue;

  // The generator looks one butterfly ahead so the read outputs can be registered.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    w_gen_layer = r_layer;
    w_gen_j     = r_j + 7'd1;
    w_gen_intt  = r_intt;
    unique case (r_state)
      ST_IDLE: begin
        w_gen_layer = i_intt ? last_layer(i_algo) : 3'd0;
        w_gen_j     = '0;
        w_gen_intt  = i_intt;
      end
      ST_DRAIN: begin
        w_gen_layer = r_intt ? (r_layer - 3'd1) : (r_layer + 3'd1);
        w_gen_j     = '0;
      end
      default: ;
    endcase
  end

  assign w_last_layer = r_intt ? (r_layer == 3'd0) : (r_layer == last_layer(r_algo));

  ntt_addr_gen u_addr_gen (
    .i_layer   (w_gen_layer),
    .i_j       (w_gen_j),
    .i_intt    (w_gen_intt),
    .o_addr_a  (w_addr_a),
    .o_addr_b  (w_addr_b),
    .o_tw_addr (w_tw)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_intt      <= 1'b0;
      r_algo      <= 1'b0;
      r_layer     <= '0;
      r_j         <= '0;
      r_drain_cnt <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_addr   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every register
      // here sees the pre-edge value of every other register.
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_RUN;
            r_intt      <= i_intt;
            r_algo      <= i_algo;
            r_layer     <= w_gen_layer;
            r_j         <= '0;
            o_busy      <= 1'b1;
            o_rd_en     <= 1'b1;
            o_rd_addr_a <= w_addr_a;
            o_rd_addr_b <= w_addr_b;
            o_tw_addr   <= w_tw;
          end
        end
        ST_RUN: begin
          if (r_j == 7'(HALF_N - 1)) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
            o_rd_en     <= 1'b0;
          end else begin
            r_j         <= w_gen_j;
            o_rd_addr_a <= w_addr_a;
            o_rd_addr_b <= w_addr_b;
            o_tw_addr   <= w_tw;
          end
        end
        ST_DRAIN: begin
          // The last write of this layer lands in the final drain cycle.
          if (r_drain_cnt == DRAIN_CNT_W'(PIPE_LAT - 1)) begin
            if (w_last_layer) begin
              r_state <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              r_state     <= ST_RUN;
              r_layer     <= w_gen_layer;
              r_j         <= '0;
              o_rd_en     <= 1'b1;
              o_rd_addr_a <= w_addr_a;
              o_rd_addr_b <= w_addr_b;
              o_tw_addr   <= w_tw;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_issue = '{valid: o_rd_en, addr_a: o_rd_addr_a, addr_b: o_rd_addr_b};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: this delay line is plain flops, not a RAM, and is cleared so an
      // aborted transform can never emit a stray write after reset.
      for (int i = 0; i < PIPE_LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_issue;
      for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign o_wr_en     = r_dly[PIPE_LAT-1].valid;
  assign o_wr_addr_a = r_dly[PIPE_LAT-1].addr_a;
  assign o_wr_addr_b = r_dly[PIPE_LAT-1].addr_b;

  assign o_bfu_intt = r_intt;
  assign o_bfu_algo = r_algo;
  assign o_bfu_skip = 1'b0;

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Self-checking bench for ntt_layer_ctrl: read-schedule and write-back
// scoreboards plus a RAM/BFU model compared against a software transform.
`timescale 1ns/1ps
module tb_ntt_layer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       intt = 1'b0;
  logic       algo = 1'b0;
  logic       o_busy, o_done, o_rd_en, o_bfu_intt, o_bfu_algo, o_bfu_skip, o_wr_en;
  logic [7:0] o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_wr_addr_a, o_wr_addr_b;

  always #5 clk = ~clk;

  ntt_layer_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_intt      (intt),
    .i_algo      (algo),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .o_tw_addr   (o_tw_addr),
    .o_bfu_intt  (o_bfu_intt),
    .o_bfu_algo  (o_bfu_algo),
    .o_bfu_skip  (o_bfu_skip),
    .o_wr_en     (o_wr_en),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
  } rd_t;

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [7:0] b;
    longint     va;
    longint     vb;
  } wr_t;

  rd_t    exp_rd_q[$];
  rd_t    issue_log[$];
  wr_t    exp_wr_q[$];
  longint ram  [256];
  longint gold [256];
  longint q_mod = 3329;
  bit     exp_intt = 1'b0;
  bit     exp_algo = 1'b0;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_err = 0;
  int     done_cnt = 0;

  // Toy butterfly: CT for forward, GS for inverse; the twiddle index is the multiplier.
  function automatic void bfu(input bit inv, input longint a, input longint b,
                              input longint tw, input longint q,
                              output longint ra, output longint rb);
    longint t;
    if (!inv) begin
      t  = (tw * b) % q;
      ra = (a + t) % q;
      rb = (a - t + q) % q;
    end else begin
      ra = (a + b) % q;
      rb = (tw * ((b - a + q) % q)) % q;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: read schedule, write-back alignment, mode outputs and the RAM model.
  initial begin
    rd_t    got, e;
    wr_t    w;
    longint va, vb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_busy) begin
          n_cmp++;
          if (o_bfu_intt !== exp_intt || o_bfu_algo !== exp_algo || o_bfu_skip !== 1'b0) begin
            n_err++;
            $display("FAIL bfu_mode cyc=%0d got intt=%b algo=%b skip=%b want intt=%b algo=%b skip=0",
                     cyc, o_bfu_intt, o_bfu_algo, o_bfu_skip, exp_intt, exp_algo);
          end
        end
        if (o_rd_en) begin
          got = '{o_rd_addr_a, o_rd_addr_b, o_tw_addr};
          issue_log.push_back(got);
          n_cmp++;
          if (exp_rd_q.size() == 0) begin
            n_err++;
            $display("FAIL rd_extra cyc=%0d got a=%0d b=%0d tw=%0d want no read",
                     cyc, got.a, got.b, got.tw);
          end else begin
            e = exp_rd_q.pop_front();
            if (got.a !== e.a || got.b !== e.b || got.tw !== e.tw) begin
              n_err++;
              $display("FAIL rd_addr cyc=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d",
                       cyc, got.a, got.b, got.tw, e.a, e.b, e.tw);
            end
          end
          bfu(exp_intt, ram[o_rd_addr_a], ram[o_rd_addr_b], longint'(o_tw_addr), q_mod, va, vb);
          exp_wr_q.push_back('{cyc + 5, o_rd_addr_a, o_rd_addr_b, va, vb});
        end
        if (o_wr_en) begin
          n_cmp++;
          if (exp_wr_q.size() == 0) begin
            n_err++;
            $display("FAIL wr_extra cyc=%0d got a=%0d b=%0d want no write", cyc, o_wr_addr_a, o_wr_addr_b);
          end else begin
            w = exp_wr_q.pop_front();
            if (w.due != cyc || o_wr_addr_a !== w.a || o_wr_addr_b !== w.b) begin
              n_err++;
              $display("FAIL wr_align got cyc=%0d a=%0d b=%0d want cyc=%0d a=%0d b=%0d",
                       cyc, o_wr_addr_a, o_wr_addr_b, w.due, w.a, w.b);
            end
            ram[o_wr_addr_a] = w.va;
            ram[o_wr_addr_b] = w.vb;
          end
        end else if (exp_wr_q.size() > 0 && exp_wr_q[0].due < cyc) begin
          n_cmp++;
          n_err++;
          w = exp_wr_q.pop_front();
          $display("FAIL wr_missing cyc=%0d got no write want a=%0d b=%0d at cyc=%0d",
                   cyc, w.a, w.b, w.due);
        end
        if (o_done) done_cnt++;
      end
    end
  end

  // Runs one transform; glitch_at pulses i_start mid-run, abort_at resets mid-run.
  task automatic run_transform(input bit inv, input bit alg, input int glitch_at, input int abort_at);
    int     nl, lyr, len, g, c0, dcyc, done0, bad, k_tw;
    bit     got, aborted;
    longint zeta, ra, rb;
    rd_t    e;
    nl = alg ? 8 : 7;
    q_mod = alg ? 64'd8380417 : 64'd3329;
    exp_rd_q.delete();
    exp_wr_q.delete();
    issue_log.delete();
    for (int s = 0; s < nl; s++) begin
      lyr = inv ? (nl - 1 - s) : s;
      len = 128 >> lyr;
      for (int j = 0; j < 128; j++) begin
        g    = j / len;
        e.a  = 8'(2 * len * g + (j % len));
        e.b  = 8'(2 * len * g + (j % len) + len);
        e.tw = inv ? 8'((2 << lyr) - 1 - g) : 8'((1 << lyr) + g);
        exp_rd_q.push_back(e);
      end
    end
    for (int i = 0; i < 256; i++) begin
      ram[i]  = longint'($urandom_range(32'(q_mod - 1)));
      gold[i] = ram[i];
    end
    if (!inv) begin
      k_tw = 1;
      for (int ln = 128; ln >= (alg ? 1 : 2); ln >>= 1)
        for (int st = 0; st < 256; st += 2 * ln) begin
          zeta = longint'(k_tw);
          k_tw++;
          for (int j = st; j < st + ln; j++) begin
            bfu(1'b0, gold[j], gold[j+ln], zeta, q_mod, ra, rb);
            gold[j] = ra;
            gold[j+ln] = rb;
          end
        end
    end else begin
      k_tw = (1 << nl) - 1;
      for (int ln = (alg ? 1 : 2); ln <= 128; ln <<= 1)
        for (int st = 0; st < 256; st += 2 * ln) begin
          zeta = longint'(k_tw);
          k_tw--;
          for (int j = st; j < st + ln; j++) begin
            bfu(1'b1, gold[j], gold[j+ln], zeta, q_mod, ra, rb);
            gold[j] = ra;
            gold[j+ln] = rb;
          end
        end
    end
    exp_intt = inv;
    exp_algo = alg;
    @(negedge clk);
    c0 = cyc;
    done0 = done_cnt;
    start = 1'b1;
    intt = inv;
    algo = alg;
    got = 1'b0;
    aborted = 1'b0;
    dcyc = 0;
    for (int k = 1; k <= 1300 && !got && !aborted; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        intt = ~inv;
        algo = ~alg;
        n_cmp++;
        if (o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_rise got %b want 1", o_busy);
        end
      end
      if (k == glitch_at) begin
        start = 1'b1;
      end
      if (k == glitch_at + 1) start = 1'b0;
      if (k == abort_at) begin
        n_cmp++;
        if (o_busy !== 1'b1 || o_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL abort_in_drain got busy=%b rd_en=%b want busy=1 rd_en=0", o_busy, o_rd_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_wr_q.delete();
        exp_rd_q.delete();
        n_cmp++;
        if ({o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_bfu_intt, o_bfu_algo,
             o_bfu_skip, o_wr_en, o_wr_addr_a, o_wr_addr_b} !== '0) begin
          n_err++;
          $display("FAIL abort_outputs got busy=%b rd_en=%b rd_a=%0d wr_en=%b wr_a=%0d algo=%b want all 0",
                   o_busy, o_rd_en, o_rd_addr_a, o_wr_en, o_wr_addr_a, o_bfu_algo);
        end
        aborted = 1'b1;
      end
      if (o_done && !aborted) begin
        got = 1'b1;
        dcyc = cyc - c0;
      end
    end
    if (aborted) begin
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (k == 3) rst_n = 1'b1;
        if (o_wr_en !== 1'b0 || o_rd_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL abort_quiet got %0d active cycles want 0", bad);
      end
      return;
    end
    n_cmp++;
    if (!got || dcyc != nl * 133 + 1) begin
      n_err++;
      $display("FAIL done_latency got seen=%b cycles=%0d want seen=1 cycles=%0d", got, dcyc, nl * 133 + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_fall got busy=%b done=%b want 0 0", o_busy, o_done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt - done0 != 1 || issue_log.size() != nl * 128 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      n_err++;
      $display("FAIL run_totals got dones=%0d issues=%0d rd_left=%0d wr_left=%0d want 1 %0d 0 0",
               done_cnt - done0, issue_log.size(), exp_rd_q.size(), exp_wr_q.size(), nl * 128);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] != gold[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ram_vs_golden got %0d wrong coefficients want 0", bad);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_bfu_intt, o_bfu_algo,
         o_bfu_skip, o_wr_en, o_wr_addr_a, o_wr_addr_b} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b rd_en=%b wr_en=%b want all 0", o_busy, o_rd_en, o_wr_en);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_wr_en !== 1'b0 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got busy=%b rd_en=%b wr_en=%b done=%b want 0", o_busy, o_rd_en, o_wr_en, o_done);
    end
  endtask

  task automatic test_dil_fwd();
    run_transform(1'b0, 1'b1, -10, -10);
    n_cmp++;
    if (issue_log.size() != 1024 || issue_log[0].a !== 8'd0 || issue_log[0].b !== 8'd128 || issue_log[0].tw !== 8'd1 ||
        issue_log[1023].a !== 8'd254 || issue_log[1023].b !== 8'd255 || issue_log[1023].tw !== 8'd255) begin
      n_err++;
      $display("FAIL dil_fwd_spot got first=%0d/%0d/%0d want 0/128/1 and last 254/255/255 (issues=%0d)",
               issue_log[0].a, issue_log[0].b, issue_log[0].tw, issue_log.size());
    end
  endtask

  task automatic test_dil_inv();
    run_transform(1'b1, 1'b1, -10, -10);
    n_cmp++;
    if (issue_log.size() != 1024 || issue_log[0].a !== 8'd0 || issue_log[0].b !== 8'd1 || issue_log[0].tw !== 8'd255 ||
        issue_log[127].a !== 8'd254 || issue_log[127].b !== 8'd255 || issue_log[127].tw !== 8'd128 ||
        issue_log[896].a !== 8'd0 || issue_log[896].b !== 8'd128 || issue_log[896].tw !== 8'd1) begin
      n_err++;
      $display("FAIL dil_inv_spot got j0=%0d/%0d/%0d j127 tw=%0d last-layer j0=%0d/%0d/%0d",
               issue_log[0].a, issue_log[0].b, issue_log[0].tw, issue_log[127].tw,
               issue_log[896].a, issue_log[896].b, issue_log[896].tw);
    end
  endtask

  task automatic test_kyber_fwd();
    run_transform(1'b0, 1'b0, -10, -10);
    n_cmp++;
    if (issue_log.size() != 896 || issue_log[769].a !== 8'd1 || issue_log[769].b !== 8'd3 || issue_log[769].tw !== 8'd64) begin
      n_err++;
      $display("FAIL kyber_fwd_spot got L6 j1=%0d/%0d/%0d issues=%0d want 1/3/64 issues=896",
               issue_log[769].a, issue_log[769].b, issue_log[769].tw, issue_log.size());
    end
  endtask

  task automatic test_kyber_inv();
    run_transform(1'b1, 1'b0, -10, -10);
  endtask

  task automatic test_start_during_busy();
    run_transform(1'b0, 1'b1, 3 * 133 + 64, -10);
  endtask

  task automatic test_reset_mid_drain();
    run_transform(1'b0, 1'b1, -10, 264);
    run_transform(1'b0, 1'b1, -10, -10);
  endtask

  initial begin
    test_reset();
    test_dil_fwd();
    test_dil_inv();
    test_kyber_fwd();
    test_kyber_inv();
    test_start_during_busy();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
